ps2_keymap: RTL and testbench
=============================

# ps2_keymap

Translates PS/2 scan-code-set-2 symbols from the `ps2phy` stage into ASCII bytes for the CPU keyboard port. It sits between `ps2phy` (`sym_*`) and the core (`kb_*`). It tracks prefix bytes and modifier state (shift, ctrl, caps lock) and emits one byte per printable or control key press. A small FIFO absorbs bursts while the core is busy.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sym_data` in 8: raw scan-code byte from `ps2phy`.
- `sym_valid` in 1: `sym_data` valid.
- `sym_ready` out 1: byte accepted when `sym_valid & sym_ready`.
- `kb_data` out 8: translated character, FIFO head.
- `kb_valid` out 1: FIFO non-empty.
- `kb_ready` in 1: core pops head when `kb_valid & kb_ready`.
- `mods` out 4: {caps_lock, ctrl, shift_r, shift_l}, registered.

## Operation
- **Decoder FSM.** States are `IDLE`, `EXT`, `BRK`, `EXT_BRK`, `SKIP`.
  - `IDLE` + `E0` → `EXT`.
  - `IDLE` + `F0` → `BRK`.
  - `EXT` + `F0` → `EXT_BRK`.
  - `E1` in any state → `SKIP` with a 3-bit counter loaded to 7. `SKIP` discards 7 bytes (pause sequence), then returns to `IDLE`.
  - Any other byte in `IDLE`/`EXT` is a make. In `BRK`/`EXT_BRK` it is a break. The FSM returns to `IDLE` after it.
- **Ignored bytes.** `FA`, `EE`, `FE`, `00`, `FF` in `IDLE` are dropped. `AA` (BAT) is dropped and clears shift_l, shift_r and ctrl; caps_lock is kept.
- **Modifiers.**
  - `12` sets/clears shift_l on make/break.
  - `59` sets/clears shift_r.
  - `14` and `E0 14` set/clear ctrl.
  - `58` make toggles caps_lock; its break does nothing.
  - Modifier keys never emit.
- **Emitted codes, make only.** Break codes never emit.
  - Letters `1C`..: 'a'–'z'. Uppercase when (shift_l|shift_r) XOR caps_lock.
  - Digits and punctuation: US layout; shift selects the shifted glyph. caps_lock does not affect them.
  - `29` → 0x20, `5A`/`E0 5A` → 0x0D, `66` → 0x08, `0D` → 0x09, `76` → 0x1B.
  - `E0 75`/`72`/`6B`/`74` → 0x80/0x81/0x82/0x83 (up/down/left/right).
  - All other codes are dropped.
- **Ctrl.** When ctrl is set and the base char is a letter, emit `letter & 0x1F`, e.g. ctrl+C → 0x03. Ctrl has no effect on non-letters.
- **Backpressure.** `sym_ready = ~fifo_full`, registered-state based. It is deasserted for every byte when full, including modifiers. No data is ever lost.

## Timing
- **Reset values.** FSM `IDLE`, counter 0, `mods` = 0, FIFO empty, `kb_valid` = 0, `kb_data` = 0, `sym_ready` = 1.
- **Latency.** A byte accepted at edge N appears with `kb_valid` = 1 after edge N, i.e. in cycle N+1, when the FIFO was empty.
- **Modifier updates.** A modifier byte accepted at edge N takes effect for a make accepted at edge N+1. `mods` updates at edge N.
- **Simultaneous push and pop.** Both occur. When full, `sym_ready` = 0, so a same-cycle pop does not admit a push in that cycle.
- **Pointers.** FIFO pointers wrap modulo `FIFO_DEPTH`. `count` is `$clog2(FIFO_DEPTH)+1` bits wide.
- **Reset mid-sequence.** `rst_n` low at any time returns all state to reset values immediately. A partial `E0`/`F0` prefix is lost.

## Structure
- Package `ps2_keymap_pkg` holds:
  - State enum.
  - Scan-code constants (`SC_EXT`, `SC_BRK`, `SC_PAUSE`, `SC_BAT`, modifier codes).
  - Output constants (`KEY_UP`..`KEY_RIGHT`, `ASCII_CR`, etc.).
  - Pure function `map_scancode(ext, code, shift, caps)` returning {valid, char}.
- Sub-module `byte_fifo` (params `WIDTH` = 8, `DEPTH`): valid/ready push/pop, `full` output, async active-low reset.

## Test plan
- Feed `1C`, `F0 1C` with `kb_ready` = 1 → exactly one byte 0x61, `kb_valid` in cycle after acceptance; `mods` = 0.
- Feed `12 1C F0 12 F0 1C` → 0x41. Then `58 F0 58 1C` → 0x41, `mods[3]` = 1. Then `12 1C` → 0x61.
- Feed `14 21 F0 21 F0 14` (ctrl+C) → 0x03. Then `E0 75 E0 F0 75` → 0x80 only.
- Feed pause sequence `E1 14 77 E1 F0 14 F0 77` then `29` → only 0x20; ctrl stays 0.
- `kb_ready` = 0, send 5 letter makes → 4 queued, `sym_ready` = 0 on the 5th until one pop. All 5 then drain in order.
- Assert `rst_n` low after `E0 F0`, release, feed `1C` → 0x61; `mods` = 0 and FIFO empty immediately at reset.

Source files
------------

// File: rtl/ps2_keymap_pkg.sv
// ps2_keymap_pkg: decoder states, scan-code/output constants and the set-2 to ASCII map
package ps2_keymap_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [7:0] SC_BAT     = 8'hAA;
  localparam logic [7:0] SC_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_SHIFT_R = 8'h59;
  localparam logic [7:0] SC_CTRL    = 8'h14;
  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] KEY_UP     = 8'h80;
  localparam logic [7:0] KEY_DOWN   = 8'h81;
  localparam logic [7:0] KEY_LEFT   = 8'h82;
  localparam logic [7:0] KEY_RIGHT  = 8'h83;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_TAB  = 8'h09;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  // Protocol chatter (acks, echoes, resends, errors) that never carries a key.
  function automatic logic is_ignored(input logic [7:0] code);
    return code == 8'hFA || code == 8'hEE || code == 8'hFE || code == 8'h00 || code == 8'hFF;
  endfunction
  // Returns {valid, char}; letters follow shift^caps, other glyphs follow shift only.
  function automatic logic [8:0] map_scancode(input logic ext, input logic [7:0] code,
                                              input logic shift, input logic caps);
    logic [7:0] l, n, s;
    l = '0;
    n = '0;
    s = '0;
    if (ext) begin
      case (code)
        8'h75:   n = KEY_UP;
        8'h72:   n = KEY_DOWN;
        8'h6B:   n = KEY_LEFT;
        8'h74:   n = KEY_RIGHT;
        8'h5A:   n = ASCII_CR;
        default: n = '0;
      endcase
      s = n;
    end else begin
      case (code)
        8'h1C: l = "a";  8'h32: l = "b";  8'h21: l = "c";  8'h23: l = "d";
        8'h24: l = "e";  8'h2B: l = "f";  8'h34: l = "g";  8'h33: l = "h";
        8'h43: l = "i";  8'h3B: l = "j";  8'h42: l = "k";  8'h4B: l = "l";
        8'h3A: l = "m";  8'h31: l = "n";  8'h44: l = "o";  8'h4D: l = "p";
        8'h15: l = "q";  8'h2D: l = "r";  8'h1B: l = "s";  8'h2C: l = "t";
        8'h3C: l = "u";  8'h2A: l = "v";  8'h1D: l = "w";  8'h22: l = "x";
        8'h35: l = "y";  8'h1A: l = "z";
        8'h16: {n, s} = {"1", "!"};  8'h1E: {n, s} = {"2", "@"};
        8'h26: {n, s} = {"3", "#"};  8'h25: {n, s} = {"4", "$"};
        8'h2E: {n, s} = {"5", "%"};  8'h36: {n, s} = {"6", "^"};
        8'h3D: {n, s} = {"7", "&"};  8'h3E: {n, s} = {"8", "*"};
        8'h46: {n, s} = {"9", "("};  8'h45: {n, s} = {"0", ")"};
        8'h0E: {n, s} = {8'h60, "~"};  8'h4E: {n, s} = {"-", "_"};
        8'h55: {n, s} = {"=", "+"};  8'h54: {n, s} = {"[", "{"};
        8'h5B: {n, s} = {"]", "}"};  8'h5D: {n, s} = {"\\", "|"};
        8'h4C: {n, s} = {";", ":"};  8'h52: {n, s} = {"'", "\""};
        8'h41: {n, s} = {",", "<"};  8'h49: {n, s} = {".", ">"};
        8'h4A: {n, s} = {"/", "?"};
        8'h29: {n, s} = {ASCII_SP, ASCII_SP};
        8'h5A: {n, s} = {ASCII_CR, ASCII_CR};
        8'h66: {n, s} = {ASCII_BS, ASCII_BS};
        8'h0D: {n, s} = {ASCII_TAB, ASCII_TAB};
        8'h76: {n, s} = {ASCII_ESC, ASCII_ESC};
        default: l = '0;
      endcase
    end
    return l != '0 ? {1'b1, (shift ^ caps) ? l ^ 8'h20 : l} : {n != '0, shift ? s : n};
  endfunction
endpackage

// File: rtl/ps2_keymap_fifo.sv
// byte_fifo: small valid/ready FIFO; head reads as zero while empty
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic push, pop;
  assign full       = count == (AW+1)'(DEPTH);
  assign push_ready = ~full;
  assign pop_valid  = count != '0;
  assign pop_data   = pop_valid ? mem[rd] : '0;
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;
  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
    end else begin
      wr    <= push ? wr + AW'(1) : wr;
      rd    <= pop ? rd + AW'(1) : rd;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk)
    if (push) mem[wr] <= push_data;
endmodule

// File: rtl/ps2_keymap.sv
// ps2_keymap: set-2 scan codes to ASCII with prefix/modifier tracking and an output FIFO
module ps2_keymap
  import ps2_keymap_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [7:0] kb_data,
  output logic       kb_valid,
  input  logic       kb_ready,
  output logic [3:0] mods
);
  logic [2:0] state, nxt_state, cnt, nxt_cnt;
  logic [3:0] nxt_mods;
  logic [8:0] m;
  logic [7:0] lc, ch;
  logic accept, mk, ext, emit, full, room, letter;
  assign sym_ready = ~full;
  assign accept    = sym_valid & sym_ready;
  assign mk        = state == ST_IDLE || state == ST_EXT;
  assign ext       = state == ST_EXT || state == ST_EXT_BRK;
  assign m         = map_scancode(ext, sym_data, mods[0] | mods[1], mods[3]);
  assign lc        = m[7:0] | 8'h20;
  assign letter    = m[7:6] == 2'b01 && lc >= "a" && lc <= "z";
  assign ch        = mods[2] && letter ? m[7:0] & 8'h1F : m[7:0];
  // Next decoder state, skip counter and modifiers for the accepted byte.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_mods  = mods;
    emit      = 1'b0;
    if (accept) begin
      if (state == ST_SKIP) begin
        nxt_cnt   = cnt - 3'd1;
        nxt_state = cnt == 3'd1 ? ST_IDLE : ST_SKIP;
      end else if (sym_data == SC_PAUSE) begin
        nxt_state = ST_SKIP;
        nxt_cnt   = 3'd7;
      end else if (state == ST_IDLE && sym_data == SC_EXT) begin
        nxt_state = ST_EXT;
      end else if (state == ST_IDLE && sym_data == SC_BRK) begin
        nxt_state = ST_BRK;
      end else if (state == ST_EXT && sym_data == SC_BRK) begin
        nxt_state = ST_EXT_BRK;
      end else if (state == ST_IDLE && sym_data == SC_BAT) begin
        nxt_mods[2:0] = '0;
      end else if (!(state == ST_IDLE && is_ignored(sym_data))) begin
        nxt_state = ST_IDLE;
        if (!ext && sym_data == SC_SHIFT_L) nxt_mods[0] = mk;
        if (!ext && sym_data == SC_SHIFT_R) nxt_mods[1] = mk;
        if (sym_data == SC_CTRL) nxt_mods[2] = mk;
        if (!ext && mk && sym_data == SC_CAPS) nxt_mods[3] = ~mods[3];
        emit = mk & m[8];
      end
    end
  end
  // Decoder registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mods  <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      mods  <= nxt_mods;
    end
  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_data  (ch),
    .push_valid (emit & room),
    .push_ready (room),
    .pop_data   (kb_data),
    .pop_valid  (kb_valid),
    .pop_ready  (kb_ready),
    .full       (full)
  );
endmodule

// File: tb/tb_ps2_keymap.sv
// tb_ps2_keymap: scoreboard bench for ps2_keymap
module tb_ps2_keymap;
  logic clk = 0, rst_n = 0, sym_valid = 0, kb_ready = 1;
  logic [7:0] sym_data = 0;
  logic sym_ready, kb_valid;
  logic [7:0] kb_data;
  logic [3:0] mods;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] seq[$];
  always #5 clk = ~clk;
  ps2_keymap #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .kb_data(kb_data), .kb_valid(kb_valid),
    .kb_ready(kb_ready), .mods(mods)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    sym_data  = b;
    sym_valid = 1;
    while (!sym_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", {31'b0, sym_ready}, 1);
    @(posedge clk);
    #1 sym_valid = 0;
  endtask
  task automatic send_seq();
    foreach (seq[i]) send(seq[i]);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask
  // Every byte the core accepts is compared with the oldest expected byte.
  always @(negedge clk)
    if (rst_n && kb_valid && kb_ready) begin
      if (q.size() == 0) chk("extra_output", {31'b0, kb_valid}, 0);
      else chk("kb_data", kb_data, q.pop_front());
    end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_kb_valid", kb_valid, 0);
    chk("rst_kb_data", kb_data, 0);
    chk("rst_sym_ready", sym_ready, 1);
    chk("rst_mods", mods, 0);
    rst_n = 1;
    q.push_back("a");
    send(8'h1C);
    chk("latency", kb_valid, 1);
    send(8'hF0); send(8'h1C);
    drain();
    chk("mods_plain", mods, 0);
    q.push_back("A"); q.push_back("A"); q.push_back("a");
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h12, 8'hF0, 8'h1C, 8'h58, 8'hF0, 8'h58, 8'h1C};
    send_seq();
    chk("caps_on", mods, 4'b1000);
    seq = '{8'h12, 8'h1C};
    send_seq();
    chk("caps_shift", mods, 4'b1001);
    q.push_back("!"); q.push_back("1");
    seq = '{8'h16, 8'hF0, 8'h12, 8'h58, 8'hF0, 8'h58, 8'h16};
    send_seq();
    drain();
    chk("mods_cleared", mods, 0);
    q.push_back(8'h03); q.push_back(8'h80);
    seq = '{8'h14, 8'h21, 8'hF0, 8'h21, 8'hF0, 8'h14, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    send_seq();
    drain();
    q.push_back(8'h20);
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    send_seq();
    drain();
    chk("pause_ctrl", mods, 0);
    q.push_back("a"); q.push_back(8'h0D); q.push_back(8'h08);
    seq = '{8'h12, 8'hAA, 8'hFA, 8'h1C, 8'hE0, 8'h5A, 8'h66};
    send_seq();
    drain();
    chk("bat_mods", mods, 0);
    kb_ready = 0;
    q.push_back("a"); q.push_back("b"); q.push_back("c"); q.push_back("d"); q.push_back("e");
    seq = '{8'h1C, 8'h32, 8'h21, 8'h23};
    send_seq();
    repeat (2) @(negedge clk);
    chk("full_ready", sym_ready, 0);
    chk("full_head", kb_data, "a");
    fork
      send(8'h24);
      begin
        repeat (4) @(negedge clk);
        chk("blocked", sym_ready, 0);
        @(posedge clk);
        #1 kb_ready = 1;
      end
    join
    drain();
    kb_ready = 0;
    seq = '{8'h12, 8'h1C, 8'hE0, 8'hF0};
    send_seq();
    chk("pre_rst_valid", kb_valid, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", kb_valid, 0);
    chk("mid_rst_mods", mods, 0);
    chk("mid_rst_ready", sym_ready, 1);
    @(negedge clk);
    rst_n = 1;
    kb_ready = 1;
    q.push_back("a");
    send(8'h1C);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
